// File: rtl/blowfish_feistel_if.sv
// Request and SRAM bus bundle for the Blowfish Feistel engine.
//
// Handshake: the host raises start for one cycle with datal/datar valid in
// that same cycle. The request is taken only while the engine is idle; a
// start seen while it is busy is dropped, not queued. Completion is
// signalled by a single-cycle done pulse. resultl/resultr are valid in the
// done cycle and keep their value until the next block finishes.
//
// SRAM side: two read-only ports with identical images. The engine never
// drives data_a/data_b, so they reach it as inputs from the memories.
interface blowfish_feistel_if;
    logic        start;
    logic [31:0] datal;
    logic [31:0] datar;
    logic [31:0] resultl;
    logic [31:0] resultr;
    logic        done;

    logic [11:0] addr_a;
    logic [11:0] addr_b;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        cs_a_l;
    logic        we_a_l;
    logic        oe_a_l;
    logic        cs_b_l;
    logic        we_b_l;
    logic        oe_b_l;

    // Engine side.
    modport slave (
        input  start, datal, datar, data_a, data_b,
        output resultl, resultr, done,
        output addr_a, addr_b, cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l
    );

    // Host and memory side.
    modport master (
        output start, datal, datar, data_a, data_b,
        input  resultl, resultr, done,
        input  addr_a, addr_b, cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l
    );
endinterface

// File: rtl/blowfish_feistel.sv
// Blowfish encryption of one 64-bit block. P-array and S-box lookups go
// to two identical external SRAMs, so two words can be read per access.
// Each round costs six cycles: a P read, then S0/S1 and S2/S3 read pairs.
// Every read spends one cycle presenting the address (RD_*) and a second
// cycle holding it (LT_*); data is captured on the edge that ends LT_*.
module blowfish_feistel #(
    parameter int unsigned P_ARRAY_OFFSET = 4000
) (
    input  logic                     clk,
    input  logic                     reset_l,
    blowfish_feistel_if.slave        bus,
    output logic [3:0]               o_dbg_state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_P   = 4'd1,
        LT_P   = 4'd2,
        RD_S01 = 4'd3,
        LT_S01 = 4'd4,
        RD_S23 = 4'd5,
        LT_S23 = 4'd6,
        RD_FIN = 4'd7,
        LT_FIN = 4'd8,
        DONE   = 4'd9
    } state_t;

    localparam logic [11:0] LP_P_BASE = 12'(P_ARRAY_OFFSET);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [31:0] r_sum;
    logic [3:0]  r_round;
    logic [31:0] r_resultl;
    logic [31:0] r_resultr;

    logic        w_a_en;
    logic        w_b_en;
    logic [11:0] w_addr_a;
    logic [11:0] w_addr_b;
    logic        w_done;
    logic [31:0] w_f;

    // Last stage of F: the S0+S1 sum was captured one access earlier.
    assign w_f = (r_sum ^ bus.data_a) + bus.data_b;

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus SRAM address/enable decode; ports are idle by default.
    always_comb begin
        w_next   = r_state;
        w_a_en   = 1'b0;
        w_b_en   = 1'b0;
        w_addr_a = 12'd0;
        w_addr_b = 12'd0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = RD_P;
                end
            end
            RD_P, LT_P: begin
                w_a_en   = 1'b1;
                w_addr_a = LP_P_BASE + {8'd0, r_round};
                w_next   = (r_state == RD_P) ? LT_P : RD_S01;
            end
            RD_S01, LT_S01: begin
                w_a_en   = 1'b1;
                w_b_en   = 1'b1;
                w_addr_a = {4'd0, r_l[31:24]};
                w_addr_b = 12'd256 + {4'd0, r_l[23:16]};
                w_next   = (r_state == RD_S01) ? LT_S01 : RD_S23;
            end
            RD_S23: begin
                w_a_en   = 1'b1;
                w_b_en   = 1'b1;
                w_addr_a = 12'd512 + {4'd0, r_l[15:8]};
                w_addr_b = 12'd768 + {4'd0, r_l[7:0]};
                w_next   = LT_S23;
            end
            LT_S23: begin
                w_a_en   = 1'b1;
                w_b_en   = 1'b1;
                w_addr_a = 12'd512 + {4'd0, r_l[15:8]};
                w_addr_b = 12'd768 + {4'd0, r_l[7:0]};
                w_next   = (r_round == 4'd15) ? RD_FIN : RD_P;
            end
            RD_FIN, LT_FIN: begin
                w_a_en   = 1'b1;
                w_b_en   = 1'b1;
                w_addr_a = LP_P_BASE + 12'd16;
                w_addr_b = LP_P_BASE + 12'd17;
                w_next   = (r_state == RD_FIN) ? LT_FIN : DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Block datapath: halves, partial F sum, round count and results.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_l       <= 32'd0;
            r_r       <= 32'd0;
            r_sum     <= 32'd0;
            r_round   <= 4'd0;
            r_resultl <= 32'd0;
            r_resultr <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_l     <= bus.datal;
                        r_r     <= bus.datar;
                        r_round <= 4'd0;
                    end
                end
                LT_P: begin
                    r_l <= r_l ^ bus.data_a;
                end
                LT_S01: begin
                    r_sum <= bus.data_a + bus.data_b;
                end
                LT_S23: begin
                    r_l <= r_r ^ w_f;
                    r_r <= r_l;
                    // Round 15 is the last; holding it keeps the count from wrapping.
                    if (r_round != 4'd15) begin
                        r_round <= r_round + 4'd1;
                    end
                end
                LT_FIN: begin
                    // The final swap is folded into which half gets which P word.
                    r_resultr <= r_l ^ bus.data_a;
                    r_resultl <= r_r ^ bus.data_b;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.addr_a  = w_addr_a;
    assign bus.addr_b  = w_addr_b;
    assign bus.cs_a_l  = ~w_a_en;
    assign bus.oe_a_l  = ~w_a_en;
    assign bus.we_a_l  = 1'b1;
    assign bus.cs_b_l  = ~w_b_en;
    assign bus.oe_b_l  = ~w_b_en;
    assign bus.we_b_l  = 1'b1;
    assign bus.done    = w_done;
    assign bus.resultl = r_resultl;
    assign bus.resultr = r_resultr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_blowfish_feistel.sv
// Bench for blowfish_feistel: SRAM image model, software Blowfish reference,
// per-cycle bus expectations and directed/randomised block runs.
module tb_blowfish_feistel;

    localparam int          OFF      = 4000;
    localparam logic [29:0] BUS_IDLE = 30'h0000_003F;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    blowfish_feistel_if bus ();

    blowfish_feistel #(
        .P_ARRAY_OFFSET(OFF)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [31:0] mem   [0:4095];
    logic [31:0] p_arr [0:17];
    logic [31:0] s_arr [0:3][0:255];

    // Unselected ports return junk so a control fault corrupts the result.
    assign bus.data_a = (!bus.cs_a_l && !bus.oe_a_l) ? mem[bus.addr_a] : 32'hDEAD_BEEF;
    assign bus.data_b = (!bus.cs_b_l && !bus.oe_b_l) ? mem[bus.addr_b] : 32'hBAAD_F00D;

    task automatic load_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        for (int t = 0; t < 4; t++)
            for (int j = 0; j < 256; j++) mem[t*256 + j] = s_arr[t][j];
        for (int i = 0; i < 18; i++) mem[OFF + i] = p_arr[i];
    endtask

    // ---------------- scoreboard ----------------
    logic [29:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] bus_word(input int a, input int b, input bit ea, input bit eb);
        return {a[11:0], b[11:0], ~ea, ~ea, 1'b1, ~eb, ~eb, 1'b1};
    endfunction

    function automatic logic [29:0] obs_bus();
        return {bus.addr_a, bus.addr_b, bus.cs_a_l, bus.oe_a_l, bus.we_a_l,
                bus.cs_b_l, bus.oe_b_l, bus.we_b_l};
    endfunction

    // Standard Blowfish F function on the current S-box tables.
    function automatic logic [31:0] f_fn(input logic [31:0] x);
        return ((s_arr[0][x[31:24]] + s_arr[1][x[23:16]]) ^ s_arr[2][x[15:8]]) + s_arr[3][x[7:0]];
    endfunction

    // Software encrypt; also queues the two-cycle bus pattern of every access.
    task automatic model(input logic [31:0] xl, input logic [31:0] xr,
                         output logic [31:0] el, output logic [31:0] er);
        logic [31:0] l, r, t;
        logic [29:0] w;
        l = xl;
        r = xr;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            w = bus_word(OFF + i, 0, 1'b1, 1'b0);
            exp_q.push_back(w); exp_q.push_back(w);
            l = l ^ p_arr[i];
            w = bus_word(int'(l[31:24]), 256 + int'(l[23:16]), 1'b1, 1'b1);
            exp_q.push_back(w); exp_q.push_back(w);
            w = bus_word(512 + int'(l[15:8]), 768 + int'(l[7:0]), 1'b1, 1'b1);
            exp_q.push_back(w); exp_q.push_back(w);
            r = r ^ f_fn(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ p_arr[16];
        l = l ^ p_arr[17];
        w = bus_word(OFF + 16, OFF + 17, 1'b1, 1'b1);
        exp_q.push_back(w); exp_q.push_back(w);
        el = l;
        er = r;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_result"}, {bus.resultl, bus.resultr}, 64'd0);
        check({tag, "_bus"}, 64'(obs_bus()), 64'(BUS_IDLE));
    endtask

    // Runs one block from an idle cycle. abort_at>0 drops reset in that
    // cycle and returns; poke_start re-pulses start at cycles 10 and 50.
    task automatic run_block(input logic [31:0] xl, input logic [31:0] xr,
                             input int abort_at, input bit poke_start);
        logic [31:0] el, er;
        model(xl, xr, el, er);
        check("idle_before_start", 64'(dbg_state), 64'd0);
        bus.start = 1'b1;
        bus.datal = xl;
        bus.datar = xr;
        step();
        bus.start = 1'b0;
        bus.datal = $urandom;
        bus.datar = $urandom;
        for (int k = 1; k <= 98; k++) begin
            if (k == abort_at) begin
                reset_l = 1'b0;
                #1;
                check_reset_outputs("abort");
                return;
            end
            check("bus_cycle", 64'(obs_bus()), 64'(exp_q.pop_front()));
            check("done_early", 64'(bus.done), 64'd0);
            if (poke_start && (k == 10 || k == 50)) begin
                bus.start = 1'b1;
                bus.datal = $urandom;
                bus.datar = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        check("done_pulse", 64'(bus.done), 64'd1);
        check("result", {bus.resultl, bus.resultr}, {el, er});
        check("bus_idle_done", 64'(obs_bus()), 64'(BUS_IDLE));
        step();
        check("done_single", 64'(bus.done), 64'd0);
        check("result_hold", {bus.resultl, bus.resultr}, {el, er});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] xl, xr, hl, hr;
        bus.start = 1'b0;
        bus.datal = 32'd0;
        bus.datar = 32'd0;
        reset_l   = 1'b0;
        for (int i = 0; i < 18; i++) p_arr[i] = 32'd0;
        for (int t = 0; t < 4; t++)
            for (int j = 0; j < 256; j++) s_arr[t][j] = 32'd0;
        load_mem();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_l = 1'b1;
        step();
        step();

        // All-zero tables: rounds only swap, the final swap undoes it.
        run_block(32'h0123_4567, 32'h89AB_CDEF, 0, 1'b0);
        check("zero_img_l", 64'(bus.resultl), 64'h89AB_CDEF);
        check("zero_img_r", 64'(bus.resultr), 64'h0123_4567);

        // S0 + S1 wraps to zero, so F is zero every round.
        for (int j = 0; j < 256; j++) begin
            s_arr[0][j] = 32'hFFFF_FFFF;
            s_arr[1][j] = 32'h0000_0001;
        end
        load_mem();
        for (int n = 0; n < 4; n++) begin
            xl = $urandom;
            xr = $urandom;
            run_block(xl, xr, 0, 1'b0);
            check("wrap_img_l", 64'(bus.resultl), 64'(xr));
            check("wrap_img_r", 64'(bus.resultr), 64'(xl));
        end

        // Random images and plaintexts against the reference encrypt.
        for (int img = 0; img < 3; img++) begin
            for (int i = 0; i < 18; i++) p_arr[i] = $urandom;
            for (int t = 0; t < 4; t++)
                for (int j = 0; j < 256; j++) s_arr[t][j] = $urandom;
            load_mem();
            for (int n = 0; n < 100; n++) begin
                run_block($urandom, $urandom, 0, 1'b0);
            end
        end

        // Start pulses while busy are dropped.
        run_block($urandom, $urandom, 0, 1'b1);
        hl = bus.resultl;
        hr = bus.resultr;
        for (int n = 0; n < 5; n++) begin
            step();
            check("poke_no_extra_done", 64'(bus.done), 64'd0);
            check("poke_idle", 64'(dbg_state), 64'd0);
        end
        check("poke_result_kept", {bus.resultl, bus.resultr}, {hl, hr});

        // Reset mid-block aborts; the next start runs a fresh block.
        run_block($urandom, $urandom, 40, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step();
            check_reset_outputs("abort_hold");
        end
        reset_l = 1'b1;
        step();
        check("after_reset_no_done", 64'(bus.done), 64'd0);
        run_block($urandom, $urandom, 0, 1'b0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
